// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
package pll_lock_supervisor_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous clear.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so the
  // two stages shift as a pipeline instead of collapsing into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset pulse, qualifies lock, retries on timeout and
// latches failure; ready is the core reset release for downstream domains.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65536) begin : g_bad_timeout
    $error("LOCK_TIMEOUT must be in 1..65536");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_retry
    $error("MAX_RETRY must be in 0..7");
  end
  if (RST_CYCLES < 2 || RST_CYCLES > 65536) begin : g_bad_rst
    $error("RST_CYCLES must be in 2..65536");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65536) begin : g_bad_stable
    $error("STABLE_CYCLES must be in 1..65536");
  end

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

  logic             rst_sync_n;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  pll_state_e       state_q;

  // NOTE: reset asserts asynchronously but releases two edges later, so no
  // flop below sees rst_n deassert close to a refclk edge.
  sync_2ff u_rst_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_sync_n),
    .d     (locked),
    .q     (lock_s)
  );

  assign state = state_q;

  // Outputs are registered alongside each transition so they always
  // describe the state being entered.
  always_ff @(posedge refclk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= ST_RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_q <= ST_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= ST_STABLE;
            cnt     <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt == RETRY_MAX) begin
              state_q <= ST_FAIL;
              fail    <= 1'b1;
            end else begin
              state_q   <= ST_RESET_PLL;
              retry_cnt <= retry_cnt + 3'd1;
            end
          end
        end
        ST_STABLE: begin
          // A dropout restarts qualification without consuming a retry.
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            cnt     <= '0;
          end else if (cnt == STABLE_LAST) begin
            state_q <= ST_RUN;
            cnt     <= '0;
            ready   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_q   <= ST_RESET_PLL;
            cnt       <= '0;
            ready     <= 1'b0;
            pll_rst   <= 1'b1;
            retry_cnt <= '0;
            loss_cnt  <= sat_inc8(loss_cnt);
          end
        end
        ST_FAIL: begin
          if (restart) begin
            state_q   <= ST_RESET_PLL;
            cnt       <= '0;
            fail      <= 1'b0;
            retry_cnt <= '0;
          end
        end
        default: begin
          state_q <= ST_RESET_PLL;
          cnt     <= '0;
          pll_rst <= 1'b1;
          ready   <= 1'b0;
          fail    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a per-cycle behavioural model plus
// hand-timed literal expectations for each scenario.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_vec = 0;
  int n_bad = 0;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #2;
  endtask

  // Behavioural model: phase plus cycles completed in that phase; lock is
  // seen through a two-deep delay line; reset release costs two edges.
  int m_phase   = P_RESET;
  int m_elapsed = 0;
  int m_retry   = 0;
  int m_loss    = 0;
  int m_rel     = 0;
  bit m_s1      = 1'b0;
  bit m_s2      = 1'b0;

  task automatic enter(input int p);
    m_phase   = p;
    m_elapsed = 0;
  endtask

  task automatic model_step(input bit lk, input bit rs);
    m_elapsed++;
    case (m_phase)
      P_RESET:  if (m_elapsed == RST_CYCLES) enter(P_WAIT);
      P_WAIT: begin
        if (lk) enter(P_STABLE);
        else if (m_elapsed == LOCK_TIMEOUT) begin
          if (m_retry == MAX_RETRY) enter(P_FAIL);
          else begin
            m_retry++;
            enter(P_RESET);
          end
        end
      end
      P_STABLE: begin
        if (!lk) enter(P_WAIT);
        else if (m_elapsed == STABLE_CYCLES) enter(P_RUN);
      end
      P_RUN: begin
        if (!lk) begin
          m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
          m_retry = 0;
          enter(P_RESET);
        end
      end
      default: begin
        if (rs) begin
          m_retry = 0;
          enter(P_RESET);
        end
      end
    endcase
  endtask

  always @(posedge refclk or negedge rst_n) begin : model
    bit lk;
    if (!rst_n) begin
      m_rel = 0; m_phase = P_RESET; m_elapsed = 0;
      m_retry = 0; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      lk   = m_s2;
      m_s2 = m_s1;
      m_s1 = locked;
      model_step(lk, restart);
    end
  end

  always @(negedge refclk) begin : compare
    check("state",     32'(state),     32'(m_phase));
    check("pll_rst",   32'(pll_rst),   32'((m_phase == P_RESET || m_phase == P_FAIL) ? 1 : 0));
    check("ready",     32'(ready),     32'((m_phase == P_RUN) ? 1 : 0));
    check("fail",      32'(fail),      32'((m_phase == P_FAIL) ? 1 : 0));
    check("retry_cnt", 32'(retry_cnt), 32'(m_retry));
    check("loss_cnt",  32'(loss_cnt),  32'(m_loss));
  end

  initial begin
    rst_n   = 1'b0;
    locked  = 1'b0;
    restart = 1'b0;

    // Reset values
    tick(3);
    check("rst_state", 32'(state), 0);
    check("rst_pll_rst", 32'(pll_rst), 1);
    check("rst_ready", 32'(ready), 0);
    check("rst_fail", 32'(fail), 0);
    check("rst_retry", 32'(retry_cnt), 0);
    check("rst_loss", 32'(loss_cnt), 0);

    // Clean lock: two release edges, then four pll_rst cycles
    rst_n = 1'b1;
    tick(5);
    check("clean_pll_rst_hi", 32'(pll_rst), 1);
    tick(1);
    check("clean_pll_rst_lo", 32'(pll_rst), 0);
    check("clean_wait", 32'(state), P_WAIT);
    tick(10);
    locked = 1'b1;
    tick(10);
    check("clean_stable", 32'(state), P_STABLE);
    check("clean_not_ready", 32'(ready), 0);
    tick(1);
    check("clean_ready", 32'(ready), 1);
    check("clean_retry", 32'(retry_cnt), 0);
    check("clean_fail", 32'(fail), 0);

    // Restart outside FAIL has no effect
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart_ignored_run", 32'(state), P_RUN);

    // Loss in RUN, 256 times: loss_cnt saturates
    for (int i = 0; i < 256; i++) begin
      locked = 1'b0;
      tick(2);
      check("loss_ready_hold", 32'(ready), 1);
      tick(1);
      check("loss_ready_fall", 32'(ready), 0);
      check("loss_pll_rst_rise", 32'(pll_rst), 1);
      check("loss_cnt", 32'(loss_cnt), (i < 255) ? i + 1 : 255);
      locked = 1'b1;
      tick(13);
      check("loss_relock_ready", 32'(ready), 1);
    end

    // Lock glitch during STABLE: drop wins over the final count, no retry
    locked = 1'b0;
    tick(3);
    check("glitch_reset", 32'(state), P_RESET);
    locked = 1'b1;
    tick(4);
    check("glitch_wait", 32'(state), P_WAIT);
    tick(1);
    check("glitch_stable", 32'(state), P_STABLE);
    tick(5);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(2);
    check("glitch_back_wait", 32'(state), P_WAIT);
    check("glitch_no_retry", 32'(retry_cnt), 0);
    tick(1);
    check("glitch_restable", 32'(state), P_STABLE);
    tick(7);
    check("glitch_not_ready", 32'(ready), 0);
    tick(1);
    check("glitch_ready", 32'(ready), 1);

    // Timeout retries, then FAIL
    locked = 1'b0;
    tick(3);
    check("to_reset", 32'(state), P_RESET);
    check("to_loss_sat", 32'(loss_cnt), 255);
    tick(4);
    check("to_wait0", 32'(state), P_WAIT);
    tick(50);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(48);
    check("to_wait0_end", 32'(state), P_WAIT);
    check("to_retry0", 32'(retry_cnt), 0);
    tick(1);
    check("to_retry1_state", 32'(state), P_RESET);
    check("to_retry1", 32'(retry_cnt), 1);
    check("to_retry1_pll_rst", 32'(pll_rst), 1);
    tick(4);
    check("to_wait1", 32'(state), P_WAIT);
    tick(100);
    check("to_retry2_state", 32'(state), P_RESET);
    check("to_retry2", 32'(retry_cnt), 2);
    tick(4);
    check("to_wait2", 32'(state), P_WAIT);
    tick(99);
    check("to_wait2_end", 32'(fail), 0);
    tick(1);
    check("to_fail_state", 32'(state), P_FAIL);
    check("to_fail", 32'(fail), 1);
    check("to_fail_pll_rst", 32'(pll_rst), 1);
    tick(20);
    check("to_fail_held", 32'(state), P_FAIL);

    // Restart from FAIL with lock already present
    locked = 1'b1;
    tick(5);
    check("fail_ignores_lock", 32'(state), P_FAIL);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart_state", 32'(state), P_RESET);
    check("restart_retry", 32'(retry_cnt), 0);
    check("restart_fail", 32'(fail), 0);
    check("restart_pll_rst", 32'(pll_rst), 1);
    tick(12);
    check("restart_not_ready", 32'(ready), 0);
    tick(1);
    check("restart_ready", 32'(ready), 1);

    // Async reset mid-WAIT_LOCK with a retry consumed
    locked = 1'b0;
    tick(3 + 4 + LOCK_TIMEOUT + 4 + 40);
    check("pre_areset_retry", 32'(retry_cnt), 1);
    #5;
    rst_n = 1'b0;
    #1;
    check("areset_state", 32'(state), 0);
    check("areset_pll_rst", 32'(pll_rst), 1);
    check("areset_retry", 32'(retry_cnt), 0);
    check("areset_loss", 32'(loss_cnt), 0);
    tick(3);
    locked = 1'b1;
    rst_n  = 1'b1;
    tick(14);
    check("areset_not_ready", 32'(ready), 0);
    tick(1);
    check("areset_ready", 32'(ready), 1);
    check("areset_loss_after", 32'(loss_cnt), 0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
